snn_seq_classifier: RTL and testbench

Parametrised successor to the fixed 30-30-30-5 single-pass network top. Runs a three-layer LIF network (lif_eng ×3, sequential layers) over T_STEPS input frames, with a valid/ready input frame handshake. Accumulates per-class output spike counts, then resolves an argmax class and presents it on a valid/ready result port. Sits between the spike encoder and the host/result interface.

---
 rtl/snn_seq_classifier.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_snn_seq_classifier.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_seq_classifier.sv
// Sequential three-layer LIF spiking classifier: one frame per timestep,
// per-class spike counting over T_STEPS frames, argmax on a valid/ready port.

// One fully-connected LIF layer that updates one output neuron per cycle.
// Weights are signed Q4.4 bytes, row-major per output neuron. An empty
// W_FILE selects an all-zero weight array; otherwise W_INIT (the image
// W_FILE was generated from) is used.
module lif_eng #(
  parameter int    N_IN   = 30,
  parameter int    N_OUT  = 30,
  parameter string W_FILE = "",
  parameter logic [N_OUT*N_IN*8-1:0] W_INIT = '0,
  parameter int    V_W    = 16,
  parameter int    THRESH = 16,  // 1.0 in Q4.4
  parameter int    LEAK   = 3    // membrane decays by v/8 per update
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_IN-1:0]  in_spikes,
  output logic             done,
  output logic [N_OUT-1:0] spikes
);
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int SUM_W = V_W + 2;
  localparam logic [N_OUT*N_IN*8-1:0] W_EFF = (W_FILE == "") ? '0 : W_INIT;
  localparam logic signed [SUM_W-1:0] V_MAX = (SUM_W'(1) <<< (V_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] V_MIN = -V_MAX - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] TH_S  = SUM_W'(THRESH);

  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [N_IN-1:0]         in_q, in_d;
  logic [N_OUT-1:0]        spk_q, spk_d;
  logic signed [V_W-1:0]   v_q [N_OUT];
  logic signed [V_W-1:0]   v_d [N_OUT];

  logic signed [7:0]       w;
  logic signed [SUM_W-1:0] syn_sum, v_cur, v_new;
  logic signed [V_W-1:0]   v_sat;
  logic                    fire;

  // Synaptic sum and leaky-integrate update for the neuron selected by idx_q.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    w       = '0;
    syn_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      w = W_EFF[(int'(idx_q) * N_IN + i) * 8 +: 8];
      if (in_q[i]) syn_sum = syn_sum + SUM_W'(w);
    end
    v_cur = SUM_W'(v_q[idx_q]);
    v_new = v_cur - (v_cur >>> LEAK) + syn_sum;
    fire  = (v_new >= TH_S);
    if (v_new > V_MAX)      v_sat = V_MAX[V_W-1:0];
    else if (v_new < V_MIN) v_sat = V_MIN[V_W-1:0];
    else                    v_sat = v_new[V_W-1:0];
  end

  // Sequencing: latch the input frame on start, then walk all output neurons.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    idx_d  = idx_q;
    in_d   = in_q;
    spk_d  = spk_q;
    v_d    = v_q;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        idx_d  = '0;
        in_d   = in_spikes;
      end
    end else begin
      spk_d[idx_q] = fire;
      v_d[idx_q]   = fire ? '0 : v_sat;
      if (idx_q == IDX_W'(N_OUT - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // State registers; membranes persist across timesteps until rst_n.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
      in_q   <= '0;
      spk_q  <= '0;
      // NOTE: the membrane array is architectural state and must be reset.
      for (int j = 0; j < N_OUT; j++) v_q[j] <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      idx_q  <= idx_d;
      in_q   <= in_d;
      spk_q  <= spk_d;
      v_q    <= v_d;
    end
  end

  assign done   = done_q;
  assign spikes = spk_q;
endmodule

module snn_seq_classifier #(
  parameter int    N_IN    = 30,
  parameter int    N_H1    = 30,
  parameter int    N_H2    = 30,
  parameter int    N_CLS   = 5,
  parameter int    T_STEPS = 16,
  parameter int    CNT_W   = 8,
  parameter string W1_FILE = "fc1_w_q44_int8.mem",
  parameter string W2_FILE = "fc2_w_q44_int8.mem",
  parameter string W3_FILE = "fc3_w_q44_int8.mem",
  parameter logic [N_H1*N_IN*8-1:0]  W1_INIT = '0,
  parameter logic [N_H2*N_H1*8-1:0]  W2_INIT = '0,
  parameter logic [N_CLS*N_H2*8-1:0] W3_INIT = '0,
  localparam int   CLS_W   = (N_CLS > 1) ? $clog2(N_CLS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN-1:0]        in_spikes,
  output logic                   busy,
  output logic                   step_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CLS_W-1:0]       class_id,
  output logic [N_CLS*CNT_W-1:0] class_cnt,
  output logic [N_CLS-1:0]       last_spikes
);
  localparam int STEP_W = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IN, S_RUN1, S_RUN2, S_RUN3, S_ACC, S_ARGMAX, S_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic               kick_q, kick_d;     // first cycle of a RUNn state
  logic [STEP_W-1:0]  step_q, step_d;
  logic [N_IN-1:0]    frame_q, frame_d;
  logic [CNT_W-1:0]   cnt_q [N_CLS];
  logic [CNT_W-1:0]   cnt_d [N_CLS];
  logic [N_CLS-1:0]   last_q, last_d;
  logic [CLS_W-1:0]   scan_q, scan_d;
  logic [CLS_W-1:0]   best_idx_q, best_idx_d;
  logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;

  logic               l1_start, l2_start, l3_start;
  logic               l1_done, l2_done, l3_done;
  logic [N_H1-1:0]    l1_spikes;
  logic [N_H2-1:0]    l2_spikes;
  logic [N_CLS-1:0]   l3_spikes;

  assign l1_start = kick_q && (state_q == S_RUN1);
  assign l2_start = kick_q && (state_q == S_RUN2);
  assign l3_start = kick_q && (state_q == S_RUN3);

  lif_eng #(.N_IN(N_IN), .N_OUT(N_H1), .W_FILE(W1_FILE), .W_INIT(W1_INIT)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(l1_start), .in_spikes(frame_q),
    .done(l1_done), .spikes(l1_spikes)
  );
  lif_eng #(.N_IN(N_H1), .N_OUT(N_H2), .W_FILE(W2_FILE), .W_INIT(W2_INIT)) u_l2 (
    .clk(clk), .rst_n(rst_n), .start(l2_start), .in_spikes(l1_spikes),
    .done(l2_done), .spikes(l2_spikes)
  );
  lif_eng #(.N_IN(N_H2), .N_OUT(N_CLS), .W_FILE(W3_FILE), .W_INIT(W3_INIT)) u_l3 (
    .clk(clk), .rst_n(rst_n), .start(l3_start), .in_spikes(l2_spikes),
    .done(l3_done), .spikes(l3_spikes)
  );

  // Next-state and datapath updates for the classification sequence.
  always_comb begin
    state_d    = state_q;
    kick_d     = 1'b0;
    step_d     = step_q;
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    scan_d     = scan_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WAIT_IN;
          step_d     = '0;
          last_d     = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
          for (int k = 0; k < N_CLS; k++) cnt_d[k] = '0;
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          frame_d = in_spikes;
          state_d = S_RUN1;
          kick_d  = 1'b1;
        end
      end
      S_RUN1: begin
        if (l1_done) begin
          state_d = S_RUN2;
          kick_d  = 1'b1;
        end
      end
      S_RUN2: begin
        if (l2_done) begin
          state_d = S_RUN3;
          kick_d  = 1'b1;
        end
      end
      S_RUN3: begin
        if (l3_done) state_d = S_ACC;
      end
      S_ACC: begin
        for (int k = 0; k < N_CLS; k++) begin
          if (cnt_q[k] != CNT_MAX) cnt_d[k] = cnt_q[k] + CNT_W'(l3_spikes[k]);
        end
        last_d = l3_spikes;
        if (step_q == STEP_W'(T_STEPS - 1)) begin
          state_d    = S_ARGMAX;
          scan_d     = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
        end else begin
          step_d  = step_q + 1'b1;
          state_d = S_WAIT_IN;
        end
      end
      S_ARGMAX: begin
        // Strict greater-than keeps the lowest index on ties.
        if (cnt_q[scan_q] > best_cnt_q) begin
          best_idx_d = scan_q;
          best_cnt_d = cnt_q[scan_q];
        end
        if (scan_q == CLS_W'(N_CLS - 1)) state_d = S_HOLD;
        else                             scan_d  = scan_q + 1'b1;
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      kick_q     <= 1'b0;
      step_q     <= '0;
      frame_q    <= '0;
      last_q     <= '0;
      scan_q     <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      for (int k = 0; k < N_CLS; k++) cnt_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      kick_q     <= kick_d;
      step_q     <= step_d;
      frame_q    <= frame_d;
      last_q     <= last_d;
      scan_q     <= scan_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign in_ready    = (state_q == S_WAIT_IN);
  assign step_done   = (state_q == S_ACC);
  assign out_valid   = (state_q == S_HOLD);
  assign class_id    = best_idx_q;
  assign last_spikes = last_q;

  for (genvar k = 0; k < N_CLS; k++) begin : g_cnt
    assign class_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end
endmodule

// File: tb/tb_snn_seq_classifier.sv
// Bench for snn_seq_classifier. The main DUT uses identity weights of 1.0
// (Q4.4 0x10) on every layer, so with threshold 1.0 each neuron fires exactly
// when its single input fires and its membrane returns to 0: class k spikes
// in a timestep iff frame bit k is set. A second DUT with empty weight-file
// names (all-zero weights) runs in lockstep and must never count anything.
module tb_snn_seq_classifier;
  localparam int N_IN    = 30;
  localparam int N_H1    = 30;
  localparam int N_H2    = 30;
  localparam int N_CLS   = 5;
  localparam int T_STEPS = 5;
  localparam int CNT_W   = 2;
  localparam int CLS_W   = 3;
  localparam int CNT_MAX = 3;
  localparam int BUDGET  = 400;

  function automatic logic [N_H1*N_IN*8-1:0] ident(input int n_out, input int n_in);
    logic [N_H1*N_IN*8-1:0] w;
    w = '0;
    for (int j = 0; j < n_out; j++) w[(j * n_in + j) * 8 +: 8] = 8'h10;
    return w;
  endfunction

  localparam logic [N_H1*N_IN*8-1:0]  W_ID     = ident(N_H1, N_IN);
  localparam logic [N_H1*N_IN*8-1:0]  W3_FULL  = ident(N_CLS, N_H2);
  localparam logic [N_CLS*N_H2*8-1:0] W3_ID    = W3_FULL[N_CLS*N_H2*8-1:0];

  logic                   clk, rst_n, start, in_valid, out_ready;
  logic [N_IN-1:0]        in_spikes;
  logic                   in_ready, busy, step_done, out_valid;
  logic [CLS_W-1:0]       class_id;
  logic [N_CLS*CNT_W-1:0] class_cnt;
  logic [N_CLS-1:0]       last_spikes;
  logic                   z_in_ready, z_busy, z_step_done, z_out_valid;
  logic [CLS_W-1:0]       z_class_id;
  logic [N_CLS*CNT_W-1:0] z_class_cnt;
  logic [N_CLS-1:0]       z_last_spikes;

  snn_seq_classifier #(
    .N_IN(N_IN), .N_H1(N_H1), .N_H2(N_H2), .N_CLS(N_CLS), .T_STEPS(T_STEPS), .CNT_W(CNT_W),
    .W1_INIT(W_ID), .W2_INIT(W_ID), .W3_INIT(W3_ID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_spikes(in_spikes), .busy(busy), .step_done(step_done), .out_valid(out_valid),
    .out_ready(out_ready), .class_id(class_id), .class_cnt(class_cnt), .last_spikes(last_spikes)
  );

  snn_seq_classifier #(
    .N_IN(N_IN), .N_H1(N_H1), .N_H2(N_H2), .N_CLS(N_CLS), .T_STEPS(T_STEPS), .CNT_W(CNT_W),
    .W1_FILE(""), .W2_FILE(""), .W3_FILE("")
  ) dut_zero (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_spikes(in_spikes), .busy(z_busy), .step_done(z_step_done), .out_valid(z_out_valid),
    .out_ready(out_ready), .class_id(z_class_id), .class_cnt(z_class_cnt),
    .last_spikes(z_last_spikes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected packed counts: per class, total hits clipped at the counter max.
  function automatic logic [N_CLS*CNT_W-1:0] pack_counts(input int hits [N_CLS]);
    logic [N_CLS*CNT_W-1:0] p;
    p = '0;
    for (int k = 0; k < N_CLS; k++)
      p[k*CNT_W +: CNT_W] = CNT_W'((hits[k] > CNT_MAX) ? CNT_MAX : hits[k]);
    return p;
  endfunction

  function automatic int argmax(input int hits [N_CLS]);
    int best, bv, v;
    best = 0;
    bv   = -1;
    for (int k = 0; k < N_CLS; k++) begin
      v = (hits[k] > CNT_MAX) ? CNT_MAX : hits[k];
      if (v > bv) begin
        bv   = v;
        best = k;
      end
    end
    return best;
  endfunction

  // Drives one full classification and checks every step and the result.
  task automatic run_class(input logic [N_IN-1:0] frames [T_STEPS], input int gap_step,
                           input int gap_len, input bit hold_test);
    int hits [N_CLS];
    logic [N_CLS*CNT_W-1:0] exp_cnt;
    int exp_cls;
    int n;
    for (int k = 0; k < N_CLS; k++) hits[k] = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    for (int s = 0; s < T_STEPS; s++) begin
      if (s == gap_step && gap_len > 0) begin
        repeat (gap_len) @(negedge clk);
        check("in_ready_in_gap", 64'(in_ready), 64'd1);
      end
      in_valid  = 1'b1;
      in_spikes = frames[s];
      n = 0;
      while (!in_ready && n < BUDGET) begin
        @(negedge clk);
        n++;
      end
      check("in_ready_seen", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid  = 1'b0;
      in_spikes = N_IN'($urandom());
      check("in_ready_low_running", 64'(in_ready), 64'd0);
      for (int k = 0; k < N_CLS; k++) hits[k] += int'(frames[s][k]);
      n = 0;
      while (!step_done && n < BUDGET) begin
        @(negedge clk);
        n++;
      end
      check("step_done_seen", 64'(step_done), 64'd1);
      @(negedge clk);
      exp_cnt = pack_counts(hits);
      check("step_done_one_cycle", 64'(step_done), 64'd0);
      check("last_spikes", 64'(last_spikes), 64'(frames[s][N_CLS-1:0]));
      check("class_cnt_step", 64'(class_cnt), 64'(exp_cnt));
      check("in_ready_after_acc", 64'(in_ready), 64'(s != T_STEPS - 1));
    end
    exp_cls = argmax(hits);
    n = 0;
    while (!out_valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("argmax_cycles", 64'(n), 64'(N_CLS));
    check("out_valid", 64'(out_valid), 64'd1);
    check("class_id", 64'(class_id), 64'(exp_cls));
    check("class_cnt", 64'(class_cnt), 64'(exp_cnt));
    check("zero_w_out_valid", 64'(z_out_valid), 64'd1);
    check("zero_w_class_id", 64'(z_class_id), 64'd0);
    check("zero_w_class_cnt", 64'(z_class_cnt), 64'd0);
    if (hold_test) begin
      for (int i = 0; i < 10; i++) begin
        start = (i % 3 == 0);
        @(negedge clk);
        check("hold_out_valid", 64'(out_valid), 64'd1);
        check("hold_class_id", 64'(class_id), 64'(exp_cls));
        check("hold_class_cnt", 64'(class_cnt), 64'(exp_cnt));
      end
      start = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_class_cnt_kept", 64'(class_cnt), 64'(exp_cnt));
    @(negedge clk);
    check("idle_no_restart", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [N_IN-1:0] fr [T_STEPS];
    int n;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_spikes = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_step_done", 64'(step_done), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_class_id", 64'(class_id), 64'd0);
    check("rst_class_cnt", 64'(class_cnt), 64'd0);
    check("rst_last_spikes", 64'(last_spikes), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All channels active every step: every count saturates, tie resolves to 0.
    for (int s = 0; s < T_STEPS; s++) fr[s] = 30'h3FFF_FFFF;
    run_class(fr, -1, 0, 1'b1);

    // Class 2 only: saturates at 3 instead of wrapping.
    for (int s = 0; s < T_STEPS; s++) fr[s] = 30'h0000_0004;
    run_class(fr, -1, 0, 1'b0);

    // Classes 1 and 3 tie at 2, class 0 at 1: lowest tied index wins.
    fr[0] = 30'h0A; fr[1] = 30'h0A; fr[2] = 30'h01; fr[3] = 30'h00; fr[4] = 30'h00;
    run_class(fr, -1, 0, 1'b0);

    // Same random frames with and without a 7-cycle input gap before frame 3.
    for (int s = 0; s < T_STEPS; s++) fr[s] = N_IN'($urandom());
    run_class(fr, 2, 7, 1'b0);
    run_class(fr, -1, 0, 1'b0);

    // Abort by reset partway through the second timestep.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid  = 1'b1;
      in_spikes = 30'h1F;
      n = 0;
      while (!in_ready && n < BUDGET) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (s == 0) begin
        n = 0;
        while (!step_done && n < BUDGET) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
      end
    end
    repeat (45) @(negedge clk);
    check("busy_before_abort", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_class_cnt", 64'(class_cnt), 64'd0);
    check("abort_last_spikes", 64'(last_spikes), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_stays_idle", 64'(busy), 64'd0);

    // Randomized classifications with random input gaps; one also holds the result.
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < T_STEPS; s++) fr[s] = N_IN'($urandom());
      run_class(fr, int'($urandom_range(0, T_STEPS - 1)), int'($urandom_range(0, 4)), r == 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
